// File: rtl/register_file_2r1w.sv
// Two-read, one-write register bank with registered read ports and
// write-through bypass so a same-cycle write is visible to the read.
module register_file_2r1w #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 3,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    output logic              rvalid_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              rvalid_b
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic              rvalid_a_q, rvalid_a_d;
    logic              rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              wr_en;

    // Entry 0 is hardwired to zero when ZERO_REG is set.
    assign wr_en = we && !((ZERO_REG != 0) && (waddr == '0));

    always_comb begin
        rd_a = mem_q[raddr_a];
        if (we && (waddr == raddr_a)) begin
            rd_a = wdata;
        end
        if ((ZERO_REG != 0) && (raddr_a == '0)) begin
            rd_a = '0;
        end
        rd_b = mem_q[raddr_b];
        if (we && (waddr == raddr_b)) begin
            rd_b = wdata;
        end
        if ((ZERO_REG != 0) && (raddr_b == '0)) begin
            rd_b = '0;
        end
    end

    always_comb begin
        mem_d = mem_q;
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
        end else if (wr_en) begin
            mem_d[waddr] = wdata;
        end
    end

    always_comb begin
        rdata_a_d  = rdata_a_q;
        rdata_b_d  = rdata_b_q;
        rvalid_a_d = 1'b0;
        rvalid_b_d = 1'b0;
        if (rst) begin
            rdata_a_d = '0;
            rdata_b_d = '0;
        end else begin
            if (re_a) begin
                rdata_a_d  = rd_a;
                rvalid_a_d = 1'b1;
            end
            if (re_b) begin
                rdata_b_d  = rd_b;
                rvalid_b_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q      <= mem_d;
        rdata_a_q  <= rdata_a_d;
        rdata_b_q  <= rdata_b_d;
        rvalid_a_q <= rvalid_a_d;
        rvalid_b_q <= rvalid_b_d;
    end

    assign rdata_a  = rdata_a_q;
    assign rdata_b  = rdata_b_q;
    assign rvalid_a = rvalid_a_q;
    assign rvalid_b = rvalid_b_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Directed bench for register_file_2r1w: one instance with ZERO_REG=1
// and one with ZERO_REG=0, both driven by the same stimulus.
module tb_register_file_2r1w;

    logic       clk = 1'b0;
    logic       rst, we, re_a, re_b;
    logic [2:0] waddr, raddr_a, raddr_b;
    logic [7:0] wdata;
    logic [7:0] rdata_a_z, rdata_b_z, rdata_a_n, rdata_b_n;
    logic       rvalid_a_z, rvalid_b_z, rvalid_a_n, rvalid_b_n;

    always #5 clk = ~clk;

    register_file_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) u_z (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_z),
        .rvalid_a(rvalid_a_z),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_z),
        .rvalid_b(rvalid_b_z)
    );

    register_file_2r1w #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(0)) u_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a_n),
        .rvalid_a(rvalid_a_n),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b_n),
        .rvalid_b(rvalid_b_n)
    );

    typedef struct packed {
        logic [1:0][7:0] da;
        logic [1:0][7:0] db;
        logic [1:0]      va;
        logic [1:0]      vb;
    } exp_t;

    exp_t            sb[$];
    logic [7:0]      mem_m [2][8];
    logic [1:0][7:0] pa, pb;
    int              total = 0;
    int              bad = 0;

    // Model index 0 mirrors u_z (zero register), 1 mirrors u_n.
    function automatic logic [7:0] mval(int k, logic [2:0] a);
        if (k == 0 && a == 3'd0) return 8'h00;
        if (we && waddr == a) return wdata;
        return mem_m[k][a];
    endfunction

    task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(string tag);
        exp_t e;
        logic [1:0][7:0] oda, odb;
        logic [1:0]      ova, ovb;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e.va[k] = 1'b0;
                e.vb[k] = 1'b0;
                e.da[k] = 8'h00;
                e.db[k] = 8'h00;
            end else begin
                e.va[k] = re_a;
                e.vb[k] = re_b;
                e.da[k] = re_a ? mval(k, raddr_a) : pa[k];
                e.db[k] = re_b ? mval(k, raddr_b) : pb[k];
            end
            pa[k] = e.da[k];
            pb[k] = e.db[k];
        end
        sb.push_back(e);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 8; i++) mem_m[k][i] = 8'h00;
            end else if (we && !(k == 0 && waddr == 3'd0)) begin
                mem_m[k][waddr] = wdata;
            end
        end
        @(posedge clk);
        #1;
        oda = {rdata_a_n, rdata_a_z};
        odb = {rdata_b_n, rdata_b_z};
        ova = {rvalid_a_n, rvalid_a_z};
        ovb = {rvalid_b_n, rvalid_b_z};
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("%s.%0d.rdata_a", tag, k), oda[k], e.da[k]);
                chk($sformatf("%s.%0d.rdata_b", tag, k), odb[k], e.db[k]);
                chk($sformatf("%s.%0d.rvalid_a", tag, k),
                    {7'd0, ova[k]}, {7'd0, e.va[k]});
                chk($sformatf("%s.%0d.rvalid_b", tag, k),
                    {7'd0, ovb[k]}, {7'd0, e.vb[k]});
            end
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re_a = 1'b0; raddr_a = '0; re_b = 1'b0; raddr_b = '0;
        for (int k = 0; k < 2; k++) begin
            pa[k] = 8'h00;
            pb[k] = 8'h00;
            for (int i = 0; i < 8; i++) mem_m[k][i] = 8'hxx;
        end
        re_a = 1'b1; re_b = 1'b1;
        step("rst0");
        step("rst1");

        rst = 1'b0;
        for (int a = 0; a < 8; a++) begin
            raddr_a = 3'(a);
            raddr_b = 3'(7 - a);
            step("rst_sweep");
        end

        re_a = 1'b0; re_b = 1'b0;
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5;
        step("wr3");
        waddr = 3'd5; wdata = 8'h3C;
        step("wr5");
        we = 1'b0;
        re_a = 1'b1; raddr_a = 3'd3; re_b = 1'b1; raddr_b = 3'd5;
        step("rd35");

        re_a = 1'b0; re_b = 1'b0;
        we = 1'b1; waddr = 3'd2; wdata = 8'h11;
        step("wr2");
        wdata = 8'h77; re_a = 1'b1; raddr_a = 3'd2;
        step("bypass");
        we = 1'b0;
        step("rd2");

        re_a = 1'b0;
        we = 1'b1; waddr = 3'd0; wdata = 8'hFF;
        step("wr0");
        we = 1'b0;
        re_a = 1'b1; raddr_a = 3'd0; re_b = 1'b1; raddr_b = 3'd0;
        step("rd0");
        we = 1'b1; wdata = 8'hFF;
        step("wrrd0");

        we = 1'b0; re_b = 1'b0;
        raddr_a = 3'd3;
        step("rd3");
        re_a = 1'b0;
        we = 1'b1; waddr = 3'd3; wdata = 8'h00;
        repeat (3) step("hold");

        waddr = 3'd4; wdata = 8'h99;
        re_a = 1'b1; raddr_a = 3'd4; re_b = 1'b1; raddr_b = 3'd3;
        rst = 1'b1;
        step("rst_mid");
        rst = 1'b0; we = 1'b0;
        raddr_a = 3'd3; raddr_b = 3'd4;
        step("after_rst");

        for (int i = 0; i < 32; i++) begin
            we      = 1'($urandom_range(0, 1));
            waddr   = 3'($urandom_range(0, 7));
            wdata   = 8'($urandom_range(0, 255));
            re_a    = 1'($urandom_range(0, 1));
            raddr_a = 3'($urandom_range(0, 7));
            re_b    = 1'($urandom_range(0, 1));
            raddr_b = 3'($urandom_range(0, 7));
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file_2r1w.md
Name: register_file_2r1w

Overview:
- Multi-bit, multi-entry register bank for the CPU datapath, built from the same select-gated storage concept as the 1-bit register cell.
- It provides one synchronous write port and two independent registered read ports, with read-after-write bypass.
- Sits between the decode stage, which drives the read addresses, and the writeback stage, which drives the write port.

Parameters:
- DATA_W, 8, width of each register in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 reads as 0 and ignores writes; when 0, entry 0 is an ordinary register.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- we  input  1  write select; write occurs on the rising edge when high.
- waddr  input  ADDR_W  write address.
- wdata  input  DATA_W  write data.
- re_a  input  1  read request, port A.
- raddr_a  input  ADDR_W  read address, port A.
- rdata_a  output  DATA_W  registered read data, port A.
- rvalid_a  output  1  high for one cycle when rdata_a carries a new read result.
- re_b  input  1  read request, port B.
- raddr_b  input  ADDR_W  read address, port B.
- rdata_b  output  DATA_W  registered read data, port B.
- rvalid_b  output  1  high for one cycle when rdata_b carries a new read result.

Behaviour:
- Reset (rst high at a rising edge):
  - all 2**ADDR_W entries clear to 0;
  - rdata_a and rdata_b clear to 0;
  - rvalid_a and rvalid_b clear to 0.
  - rst has priority over we, re_a and re_b in the same cycle; no write or read takes effect.
- Write:
  - If we=1 at edge N (and rst=0), entry[waddr] takes wdata.
  - If ZERO_REG=1 and waddr=0, the write is dropped.
  - If we=0, no entry changes.
- Read, per port, ports fully independent:
  - If re_x=1 at edge N, then after edge N rdata_x = value(raddr_x) and rvalid_x=1. Latency is one cycle.
  - If re_x=0 at edge N, rvalid_x goes 0 after edge N and rdata_x holds its previous value.
  - Back-to-back reads on consecutive cycles give a continuous stream of rvalid_x=1.
- value(addr) is:
  - 0 if ZERO_REG=1 and addr=0;
  - otherwise wdata if we=1 and waddr=addr in the same cycle (write-through bypass, so the new data is returned);
  - otherwise the stored entry[addr].
- Both ports may read the same address in the same cycle; both return the same value.
- A read with re_x=1 and rst=1 in the same cycle is discarded: rvalid_x=0 and rdata_x=0 after the edge.
- No combinational path from any input to any output; all outputs come straight from flops.
- Addresses are always in range, since depth is an exact power of two; no wrap logic is needed.

Test Plan:
- Reset check: hold rst=1 for 2 cycles, then read every address on both ports -> rdata=0 for each address, rvalid=1 one cycle after each re; rvalid=0 while rst was high.
- Write/read back: write 8'hA5 to addr 3 and 8'h3C to addr 5; next cycles read A=3, B=5 -> rdata_a=8'hA5, rdata_b=8'h3C, both rvalid=1 exactly one cycle after re.
- Bypass: with entry 2 = 8'h11, in the same cycle drive we=1, waddr=2, wdata=8'h77 and re_a=1, raddr_a=2 -> rdata_a=8'h77 after that edge; a following read of addr 2 also returns 8'h77.
- Zero register (ZERO_REG=1): write 8'hFF to addr 0, then read it, including a same-cycle write+read -> rdata=8'h00 in every case. Rerun with ZERO_REG=0 -> rdata=8'hFF.
- Hold/valid pulse: read addr 3 (8'hA5), then drop re_a for 3 cycles while writing 8'h00 to addr 3 -> rvalid_a=0 for those cycles and rdata_a stays 8'hA5.
- Reset mid-operation: with we=1 (addr 4, 8'h99) and re_a=re_b=1 in the same cycle as rst=1 -> after the edge, entry 4=0, rdata_a=rdata_b=0, rvalid_a=rvalid_b=0; a subsequent read of addr 3 returns 0.
